// File: rtl/ahb_mem_responder.sv
// AHB-Lite subordinate memory: word-addressed SRAM with configurable wait
// states, two-cycle ERROR response for bad addresses, and a backdoor load
// port for preloading contents.
module ahb_mem_responder #(
   parameter int unsigned DEPTH       = 65536,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              haddr,
   input  logic [1:0]               htrans,
   input  logic                     hwrite,
   input  logic [31:0]              hwdata,
   output logic [31:0]              hrdata,
   output logic                     hready,
   output logic                     hresp,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  idx_q;
   logic           write_q;
   logic [31:0]    hrdata_q;
   logic [31:0]    mem [DEPTH];

   // htrans[0] only distinguishes NONSEQ from SEQ, which this memory ignores
   logic           unused_htrans0;
   assign unused_htrans0 = htrans[0];

   // Address decode on the live address-phase signals. BASE_ADDR is word
   // aligned, so the word offset can be taken directly from haddr[31:2].
   logic [29:0]    woff;
   logic [AW-1:0]  dec_idx;
   logic           legal;
   assign woff    = haddr[31:2] - BASE_ADDR[31:2];
   assign dec_idx = woff[AW-1:0];
   assign legal   = (haddr >= BASE_ADDR) && (haddr[1:0] == 2'b00) &&
                    ({2'b00, woff} < 32'(DEPTH));

   assign hready = !(state_q == WAIT || state_q == ERR1);
   assign hresp  = (state_q == ERR1) || (state_q == ERR2);
   assign hrdata = hrdata_q;

   logic          accept;
   assign accept = hready && htrans[1];

   // Memory access strobes. A read happens at the edge that enters DATA:
   // either leaving WAIT (captured index) or a zero-wait accept (live index).
   logic          rd_en, wr_en, fwd;
   logic [AW-1:0] rd_idx;
   assign rd_en  = (state_q == WAIT && cnt_q == 4'd0 && !write_q) ||
                   (accept && legal && WAIT_STATES == 0 && !hwrite);
   assign rd_idx = (state_q == WAIT) ? idx_q : dec_idx;
   assign wr_en  = (state_q == DATA) && write_q;
   assign fwd    = wr_en && (idx_q == rd_idx);

   // Next-state logic: a new transfer may be accepted whenever hready is high
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DATA, ERR2: begin
            if (accept) begin
               if (!legal) begin
                  state_d = ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   // Control state, captured address phase and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q   <= dec_idx;
            write_q <= hwrite;
         end
         if (rd_en)
            hrdata_q <= fwd ? hwdata : mem[rd_idx];
         else if (accept && !legal && !hwrite)
            hrdata_q <= '0;
      end
   end

   // Storage: backdoor first so a same-index bus write overrides it; a bus
   // write still pending when reset hits is dropped
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wr_en && !rst) mem[idx_q] <= hwdata;
   end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Bench for ahb_mem_responder: three instances (0, 2 and 3 wait states, the
// last one at a nonzero base), directed vectors plus random transfers
// checked against a transaction-level memory model.
module tb_ahb_mem_responder;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int NDUT  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [31:0]   haddr   [NDUT];
   logic [1:0]    htrans  [NDUT];
   logic          hwrite  [NDUT];
   logic [31:0]   hwdata  [NDUT];
   logic [31:0]   hrdata  [NDUT];
   logic          hready  [NDUT];
   logic          hresp   [NDUT];
   logic          ld_en   [NDUT];
   logic [AW-1:0] ld_addr [NDUT];
   logic [31:0]   ld_data [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ahb_mem_responder #(
         .DEPTH       (DEPTH),
         .BASE_ADDR   (g == 2 ? 32'h0000_1000 : 32'h0000_0000),
         .WAIT_STATES (g == 0 ? 0 : g + 1)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .haddr   (haddr[g]),
         .htrans  (htrans[g]),
         .hwrite  (hwrite[g]),
         .hwdata  (hwdata[g]),
         .hrdata  (hrdata[g]),
         .hready  (hready[g]),
         .hresp   (hresp[g]),
         .ld_en   (ld_en[g]),
         .ld_addr (ld_addr[g]),
         .ld_data (ld_data[g])
      );
   end

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] mdl [NDUT][DEPTH];

   typedef struct {
      int          k;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wd;
      int          low;
      bit          resp;
      logic [31:0] rd;
   } vec_t;
   vec_t tbl [13];

   function automatic int ws_of(int k);
      return (k == 0) ? 0 : k + 1;
   endfunction

   function automatic logic [31:0] base_of(int k);
      return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   function automatic bit legal_m(int k, logic [31:0] a);
      logic [31:0] off;
      if (a < base_of(k)) return 1'b0;
      off = a - base_of(k);
      return (off % 4 == 0) && (off / 4 < DEPTH);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic ld(int k, int idx, logic [31:0] d);
      @(negedge clk);
      ld_en[k] = 1'b1; ld_addr[k] = AW'(idx); ld_data[k] = d;
      @(negedge clk);
      ld_en[k] = 1'b0;
      mdl[k][idx] = d;
   endtask

   // One non-pipelined transfer; reports hready-low cycles, hresp seen while
   // stalled, hresp and hrdata in the completing cycle
   task automatic xfer(input int k, input logic [31:0] a, input bit wr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int low, output bit rl, output bit rf);
      @(negedge clk);
      haddr[k] = a; htrans[k] = 2'b10; hwrite[k] = wr; hwdata[k] = $urandom;
      @(negedge clk);
      htrans[k] = 2'b00; hwdata[k] = wd; haddr[k] = $urandom;
      low = 0; rl = 1'b0;
      while (hready[k] !== 1'b1 && low < 40) begin
         low++;
         rl |= hresp[k];
         @(negedge clk);
      end
      rf = hresp[k];
      rd = hrdata[k];
   endtask

   // Random transfer checked against the memory model
   task automatic run_chk(int k, logic [31:0] a, bit wr, logic [31:0] wd);
      logic [31:0] rd;
      int low, idx, exp_low;
      bit rl, rf, ok;
      ok      = legal_m(k, a);
      idx     = ok ? int'((a - base_of(k)) / 4) : 0;
      exp_low = ok ? ws_of(k) : 1;
      xfer(k, a, wr, wd, rd, low, rl, rf);
      chk($sformatf("rnd%0d %h cycles", k, a), 32'(low), 32'(exp_low));
      chk($sformatf("rnd%0d %h resp", k, a), 32'(rf), 32'(!ok));
      if (exp_low > 0) chk($sformatf("rnd%0d %h stall resp", k, a), 32'(rl), 32'(!ok));
      if (!wr) chk($sformatf("rnd%0d %h rdata", k, a), rd, ok ? mdl[k][idx] : 32'h0);
      else if (ok) mdl[k][idx] = wd;
   endtask

   initial begin
      logic [31:0] rd, old, a;
      int low, k, idx, sel;
      bit rl, rf;

      rst = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
         haddr[i] = '0; htrans[i] = 2'b00; hwrite[i] = 1'b0; hwdata[i] = '0;
         ld_en[i] = 1'b0; ld_addr[i] = '0; ld_data[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("reset hready %0d", i), 32'(hready[i]), 32'd1);
         chk($sformatf("reset hresp %0d", i), 32'(hresp[i]), 32'd0);
         chk($sformatf("reset hrdata %0d", i), hrdata[i], 32'h0);
      end

      // Preload every word of every instance through the backdoor
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         for (int j = 0; j < NDUT; j++) begin
            ld_en[j] = 1'b1; ld_addr[j] = AW'(i); ld_data[j] = $urandom;
            mdl[j][i] = ld_data[j];
         end
      end
      @(negedge clk);
      for (int j = 0; j < NDUT; j++) ld_en[j] = 1'b0;

      // Zero-wait write then pipelined read of the same word: forwarding
      haddr[0] = 32'h10; htrans[0] = 2'b10; hwrite[0] = 1'b1;
      @(negedge clk);
      chk("fwd write hready", 32'(hready[0]), 32'd1);
      haddr[0] = 32'h10; hwrite[0] = 1'b0; hwdata[0] = 32'hA5A5_0001;
      @(negedge clk);
      htrans[0] = 2'b00;
      chk("fwd read hready", 32'(hready[0]), 32'd1);
      chk("fwd read hresp", 32'(hresp[0]), 32'd0);
      chk("fwd read hrdata", hrdata[0], 32'hA5A5_0001);
      mdl[0][4] = 32'hA5A5_0001;

      // Bus write and backdoor load to the same word at the same edge
      @(negedge clk);
      haddr[0] = 32'h24; htrans[0] = 2'b10; hwrite[0] = 1'b1;
      @(negedge clk);
      htrans[0] = 2'b00; hwdata[0] = 32'h600D_0009;
      ld_en[0] = 1'b1; ld_addr[0] = 6'd9; ld_data[0] = 32'hBAD0_0009;
      @(negedge clk);
      ld_en[0] = 1'b0;
      mdl[0][9] = 32'h600D_0009;

      // Backdoor load at the same edge as a zero-wait read returns old data
      old = mdl[0][10];
      @(negedge clk);
      haddr[0] = 32'h28; htrans[0] = 2'b10; hwrite[0] = 1'b0;
      ld_en[0] = 1'b1; ld_addr[0] = 6'd10; ld_data[0] = 32'h1D1D_000A;
      @(negedge clk);
      htrans[0] = 2'b00; ld_en[0] = 1'b0;
      chk("ld not forwarded", hrdata[0], old);
      mdl[0][10] = 32'h1D1D_000A;

      // Idle cycle with write-looking signals must not touch memory
      ld(0, 0, 32'h0000_C0DE);
      @(negedge clk);
      haddr[0] = 32'h0; htrans[0] = 2'b00; hwrite[0] = 1'b1;
      @(negedge clk);
      hwdata[0] = 32'h5;
      chk("idle hready", 32'(hready[0]), 32'd1);
      chk("idle hresp", 32'(hresp[0]), 32'd0);
      @(negedge clk);
      chk("idle hready 2", 32'(hready[0]), 32'd1);
      hwrite[0] = 1'b0;

      ld(1, 8, 32'h1234_5678);
      //          k  addr                 wr    wdata           low resp rdata
      tbl[0]  = '{1, 32'h20,              1'b0, 32'h0,          2, 1'b0, 32'h1234_5678};
      tbl[1]  = '{0, 32'(DEPTH*4),        1'b1, 32'hFFFF_FFFF,  1, 1'b1, 32'h0};
      tbl[2]  = '{0, 32'h13,              1'b1, 32'hFFFF_FFFF,  1, 1'b1, 32'h0};
      tbl[3]  = '{0, 32'h10,              1'b0, 32'h0,          0, 1'b0, 32'hA5A5_0001};
      tbl[4]  = '{0, 32'h0,               1'b0, 32'h0,          0, 1'b0, 32'h0000_C0DE};
      tbl[5]  = '{0, 32'h24,              1'b0, 32'h0,          0, 1'b0, 32'h600D_0009};
      tbl[6]  = '{0, 32'h12,              1'b0, 32'h0,          1, 1'b1, 32'h0};
      tbl[7]  = '{1, 32'(DEPTH*4+4),      1'b0, 32'h0,          1, 1'b1, 32'h0};
      tbl[8]  = '{2, 32'h0FFC,            1'b0, 32'h0,          1, 1'b1, 32'h0};
      tbl[9]  = '{2, 32'(32'h1000+DEPTH*4), 1'b1, 32'h1,        1, 1'b1, 32'h0};
      tbl[10] = '{2, 32'h1004,            1'b1, 32'h7777_0001,  3, 1'b0, 32'h0};
      tbl[11] = '{2, 32'h1004,            1'b0, 32'h0,          3, 1'b0, 32'h7777_0001};
      tbl[12] = '{1, 32'h20,              1'b1, 32'hDEAD_BEEF,  2, 1'b0, 32'h0};
      for (int i = 0; i < 13; i++) begin
         xfer(tbl[i].k, tbl[i].addr, tbl[i].wr, tbl[i].wd, rd, low, rl, rf);
         chk($sformatf("vec%0d cycles", i), 32'(low), 32'(tbl[i].low));
         chk($sformatf("vec%0d resp", i), 32'(rf), 32'(tbl[i].resp));
         if (!tbl[i].wr) chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
         else if (!tbl[i].resp)
            mdl[tbl[i].k][(tbl[i].addr - base_of(tbl[i].k)) / 4] = tbl[i].wd;
      end

      // Reset for two cycles while a wait-stated read is in flight
      @(negedge clk);
      haddr[1] = 32'h20; htrans[1] = 2'b10; hwrite[1] = 1'b0;
      @(negedge clk);
      htrans[1] = 2'b00; rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid read hready", 32'(hready[1]), 32'd1);
      chk("rst mid read hresp", 32'(hresp[1]), 32'd0);
      chk("rst mid read hrdata", hrdata[1], 32'h0);

      // Reset during the second wait cycle of a write drops the write
      ld(2, 16, 32'h1111_2222);
      @(negedge clk);
      haddr[2] = 32'h1040; htrans[2] = 2'b10; hwrite[2] = 1'b1;
      @(negedge clk);
      htrans[2] = 2'b00; hwdata[2] = 32'hCAFE_F00D;
      chk("rst wr wait1 hready", 32'(hready[2]), 32'd0);
      @(negedge clk);
      chk("rst wr wait2 hready", 32'(hready[2]), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst wr hready after", 32'(hready[2]), 32'd1);
      chk("rst wr hresp after", 32'(hresp[2]), 32'd0);
      xfer(2, 32'h1040, 1'b0, 32'h0, rd, low, rl, rf);
      chk("rst wr mem kept", rd, 32'h1111_2222);
      chk("rst wr read cycles", 32'(low), 32'd3);

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, NDUT - 1);
         sel = $urandom_range(0, 9);
         idx = $urandom_range(0, DEPTH - 1);
         if (sel == 0) begin
            ld(k, idx, $urandom);
         end else begin
            a = base_of(k) + 32'(idx * 4);
            if (sel == 1)      a = a + 32'($urandom_range(1, 3));
            else if (sel == 2) a = base_of(k) + 32'(DEPTH * 4) + 32'(idx * 4);
            else if (sel == 3) a = base_of(k) - 32'(4 + idx * 4);
            run_chk(k, a, 1'($urandom_range(0, 1)), $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
